// File: rtl/tpu_mem_pkg.sv
// ----------------------------------------------------------------------------
// tpu_mem_pkg
//   Definitions shared by the req/rsp memory protocol initiators (transpose
//   engine, CPU ports) and the banked SRAM responder.
//   - REQ_ADDR_W / REQ_DATA_W : default request address and data widths
//   - clog2()                 : ceiling log2, usable in constant expressions
//   - bank_w()                : bank-select field width for NB banks
//   - cnt_w()                 : width of a bank recovery counter
// ----------------------------------------------------------------------------
package tpu_mem_pkg;

    localparam int REQ_ADDR_W = 16;
    localparam int REQ_DATA_W = 32;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic int bank_w(input int nb);
        return clog2(nb);
    endfunction

    // A counter must hold BANK_CYC; keep at least one bit so BANK_CYC=0 still
    // yields a legal (always-zero) counter.
    function automatic int cnt_w(input int cyc);
        return (cyc < 1) ? 1 : clog2(cyc + 1);
    endfunction

endpackage

// File: rtl/sram_bank.sv
// ----------------------------------------------------------------------------
// sram_bank
//   One single-port bank, 2^M x Data_W. Synchronous write, registered read.
//   rdata only changes on a read access and holds otherwise.
// Ports
//   clk    in   1       clock, rising edge
//   en     in   1       access this bank at this edge
//   we     in   1       1 = write wdata, 0 = read into rdata
//   addr   in   M       row address
//   wdata  in   Data_W  write data
//   rdata  out  Data_W  read data, valid the cycle after a read access
// ----------------------------------------------------------------------------
module sram_bank #(
    parameter int Data_W = 32,
    parameter int M      = 6
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [M-1:0]      addr,
    input  logic [Data_W-1:0] wdata,
    output logic [Data_W-1:0] rdata
);

    logic [Data_W-1:0] mem [2**M];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/bank_sram_responder.sv
// ----------------------------------------------------------------------------
// bank_sram_responder
//   Responder end of the req/rsp memory protocol. NB word-interleaved
//   single-port banks sit behind one request port. Reads return on a
//   fixed-latency rsp_v pulse, in acceptance order; writes return nothing.
//   A bank that was just accessed is unavailable for BANK_CYC cycles, which
//   is the only source of back-pressure (req_ready).
// Ports
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   req_v      in   1       request valid
//   req_we     in   1       1 = write, 0 = read
//   Req_addr   in   ADDR_W  word address (bank = low bits, row = next M bits)
//   Req_wData  in   Data_W  write data
//   req_ready  out  1       bank addressed by Req_addr can accept this cycle
//   Rsp_rData  out  Data_W  read data, valid when rsp_v, held otherwise
//   rsp_v      out  1       one-cycle read-response pulse
// ----------------------------------------------------------------------------
module bank_sram_responder
    import tpu_mem_pkg::*;
#(
    parameter int NB       = 8,
    parameter int ADDR_W   = REQ_ADDR_W,
    parameter int Data_W   = REQ_DATA_W,
    parameter int M        = 6,
    parameter int RD_LAT   = 2,
    parameter int BANK_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_v,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] Req_addr,
    input  logic [Data_W-1:0] Req_wData,
    output logic              req_ready,
    output logic [Data_W-1:0] Rsp_rData,
    output logic              rsp_v
);

    localparam int BW = bank_w(NB);
    localparam int CW = cnt_w(BANK_CYC);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(BANK_CYC);

    logic [BW-1:0]     req_bank;
    logic [M-1:0]      req_row;
    logic              accept;
    logic              rd_accept;
    logic [CW-1:0]     bank_cnt [NB];
    logic [NB-1:0]     bank_en;
    logic [Data_W-1:0] bank_rdata [NB];
    logic [BW-1:0]     bank_idx_p0;
    logic [Data_W-1:0] bank_mux;
    logic [RD_LAT-1:0] vld_p;

    assign req_bank = Req_addr[BW-1:0];
    assign req_row  = Req_addr[BW+M-1:BW];

    // Address bits above the bank/row fields are ignored: addresses alias.
    if (ADDR_W > BW + M) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^Req_addr[ADDR_W-1:BW+M];
    end

    // Ready looks only at the addressed bank, never at req_v, so an initiator
    // can hold its request across a stall without a combinational loop.
    assign req_ready = (bank_cnt[req_bank] == '0);
    assign accept    = req_v && req_ready;
    assign rd_accept = accept && !req_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NB; i++) begin
                bank_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (accept && (req_bank == BW'(i))) begin
                    bank_cnt[i] <= CNT_RELOAD;
                end else if (bank_cnt[i] != '0) begin
                    bank_cnt[i] <= bank_cnt[i] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        bank_en = '0;
        if (accept) begin
            bank_en[req_bank] = 1'b1;
        end
    end

    for (genvar g = 0; g < NB; g++) begin : g_bank
        sram_bank #(
            .Data_W (Data_W),
            .M      (M)
        ) u_bank (
            .clk   (clk),
            .en    (bank_en[g]),
            .we    (req_we),
            .addr  (req_row),
            .wdata (Req_wData),
            .rdata (bank_rdata[g])
        );
    end

    // ---- stage p0: bank array registers the word; remember which bank ----
    always_ff @(posedge clk) begin
        if (rd_accept) begin
            bank_idx_p0 <= req_bank;
        end
    end

    assign bank_mux = bank_rdata[bank_idx_p0];

    // Valid shift register: vld_p[k] is a read accepted k+1 edges ago.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= rd_accept;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_p[k] <= vld_p[k-1];
            end
        end
    end

    assign rsp_v = vld_p[RD_LAT-1];

    if (RD_LAT == 1) begin : g_lat1
        // ---- response stage: bank output is already aligned with rsp_v ----
        logic [Data_W-1:0] rsp_hold;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rsp_hold <= '0;
            end else if (rsp_v) begin
                rsp_hold <= bank_mux;
            end
        end

        assign Rsp_rData = rsp_v ? bank_mux : rsp_hold;
    end else begin : g_latn
        logic [Data_W-1:0] dat_tail;
        logic [Data_W-1:0] rsp_q;

        if (RD_LAT == 2) begin : g_direct
            assign dat_tail = bank_mux;
        end else begin : g_pipe
            // ---- stages p1..: delay bank data to line up with vld_p ----
            logic [Data_W-1:0] dat_p [RD_LAT-2];

            always_ff @(posedge clk) begin
                dat_p[0] <= bank_mux;
                for (int k = 1; k < RD_LAT - 2; k++) begin
                    dat_p[k] <= dat_p[k-1];
                end
            end

            assign dat_tail = dat_p[RD_LAT-3];
        end

        // ---- response stage: load only for a real response, else hold ----
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rsp_q <= '0;
            end else if (vld_p[RD_LAT-2]) begin
                rsp_q <= dat_tail;
            end
        end

        assign Rsp_rData = rsp_q;
    end

endmodule
